// File: rtl/ex_mem_stage.sv
// ex_mem_stage: memory stage with the EX/MEM pipeline register built in.
// It latches EX results on each pipeline advance, drives the data-cache
// request until dhit, captures load data and raises mem_busy while an access
// is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to build a REQ watchdog that sets
// the sticky mem_err flag after TIMEOUT_MAX cycles of waiting.
module ex_mem_stage #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic [WORD_W-1:0] alu_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic [WORD_W-1:0] next_pc_in,
  input  logic [WORD_W-1:0] instruction_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memToReg_in,
  input  logic              RegWrite_in,
  input  logic              jal_in,
  input  logic              lui_in,
  input  logic              halt_in,
  input  logic [1:0]        RegDest_in,
  input  logic [4:0]        rd_in,
  input  logic [4:0]        rt_in,
  input  logic [15:0]       imm_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] alu_out,
  output logic [WORD_W-1:0] dmemload_out,
  output logic [WORD_W-1:0] next_pc_out,
  output logic [WORD_W-1:0] instruction_out,
  output logic [15:0]       imm_out,
  output logic [4:0]        rd_out,
  output logic [4:0]        rt_out,
  output logic [1:0]        RegDest_out,
  output logic              memToReg_out,
  output logic              RegWrite_out,
  output logic              jal_out,
  output logic              lui_out,
  output logic              halt_out,
  output logic              mem_busy,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] store;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] instr;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              jal;
    logic              lui;
    logic              halt;
    logic [1:0]        reg_dest;
    logic [4:0]        rd;
    logic [4:0]        rt;
    logic [15:0]       imm;
  } ex_fields_t;

  state_t            state_q, state_d;
  ex_fields_t        ex_q, ex_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic              advance;

  // Next-state, latch load and load-data capture; ihit is ignored while an access is outstanding
  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    load_d  = load_q;
    advance = ihit & (state_q != REQ);
    case (state_q)
      REQ: begin
        if (dhit) begin
          state_d = DONE;
          if (ex_q.mem_read) begin
            load_d = dmemload;
          end
        end
      end
      default: begin
        if (advance) begin
          state_d = ((memRead_in | memWrite_in) & ~halt_in & ~flush) ? REQ : IDLE;
          if (flush) begin
            ex_d      = '0;
            ex_d.halt = ex_q.halt;
          end else begin
            ex_d.alu        = alu_in;
            ex_d.store      = store_in;
            ex_d.next_pc    = next_pc_in;
            ex_d.instr      = instruction_in;
            ex_d.mem_read   = memRead_in;
            ex_d.mem_write  = memWrite_in;
            ex_d.mem_to_reg = memToReg_in;
            ex_d.reg_write  = RegWrite_in;
            ex_d.jal        = jal_in;
            ex_d.lui        = lui_in;
            ex_d.halt       = ex_q.halt | halt_in;
            ex_d.reg_dest   = RegDest_in;
            ex_d.rd         = rd_in;
            ex_d.rt         = rt_in;
            ex_d.imm        = imm_in;
          end
        end
      end
    endcase
  end

  // State, EX/MEM latch and captured load data; halt is sticky until reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ex_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      load_q  <= load_d;
    end
  end

  assign mem_busy  = (state_q == REQ);
  assign dmemREN   = mem_busy & ex_q.mem_read;
  assign dmemWEN   = mem_busy & ex_q.mem_write;
  assign dmemaddr  = {ex_q.alu[WORD_W-1:2], 2'b00};
  assign dmemstore = ex_q.store;

  assign alu_out         = ex_q.alu;
  assign dmemload_out    = load_q;
  assign next_pc_out     = ex_q.next_pc;
  assign instruction_out = ex_q.instr;
  assign imm_out         = ex_q.imm;
  assign rd_out          = ex_q.rd;
  assign rt_out          = ex_q.rt;
  assign RegDest_out     = ex_q.reg_dest;
  assign memToReg_out    = ex_q.mem_to_reg;
  assign RegWrite_out    = ex_q.reg_write;
  assign jal_out         = ex_q.jal;
  assign lui_out         = ex_q.lui;
  assign halt_out        = ex_q.halt;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TMAX = 16'(TIMEOUT_MAX);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Watchdog: counts REQ cycles (saturating), restarts for each access, flags a stuck access
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q != REQ) || dhit) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != TMAX) begin
        cnt_d = cnt_q + 16'd1;
      end
      if (cnt_d == TMAX) begin
        err_d = 1'b1;
      end
    end
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_MAX != 0);
  assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a
// transaction-level model of the EX/MEM latch and data-cache handshake.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] store;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        jal;
    logic        lui;
    logic        halt;
    logic [1:0]  rdst;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [15:0] imm;
  } ex_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, flush = 1'b0, dhit = 1'b0;
  logic [31:0] alu_in = '0, store_in = '0, next_pc_in = '0, instruction_in = '0;
  logic        memRead_in = 1'b0, memWrite_in = 1'b0, memToReg_in = 1'b0;
  logic        RegWrite_in = 1'b0, jal_in = 1'b0, lui_in = 1'b0, halt_in = 1'b0;
  logic [1:0]  RegDest_in = '0;
  logic [4:0]  rd_in = '0, rt_in = '0;
  logic [15:0] imm_in = '0;
  logic [31:0] dmemload = '0;

  logic        dmemREN, dmemWEN, mem_busy, mem_err;
  logic [31:0] dmemaddr, dmemstore, alu_out, dmemload_out, next_pc_out, instruction_out;
  logic [15:0] imm_out;
  logic [4:0]  rd_out, rt_out;
  logic [1:0]  RegDest_out;
  logic        memToReg_out, RegWrite_out, jal_out, lui_out, halt_out;

  logic [160:0] obs;

  int          n_checks = 0;
  int          n_pass = 0;
  ex_t         exp_lat = '0;
  logic [31:0] exp_load = '0;
  logic        exp_halt = 1'b0;

  always #5 CLK = ~CLK;

  ex_mem_stage #(.WORD_W(32), .TIMEOUT_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
    .alu_in(alu_in), .store_in(store_in), .next_pc_in(next_pc_in),
    .instruction_in(instruction_in),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in), .memToReg_in(memToReg_in),
    .RegWrite_in(RegWrite_in), .jal_in(jal_in), .lui_in(lui_in), .halt_in(halt_in),
    .RegDest_in(RegDest_in), .rd_in(rd_in), .rt_in(rt_in), .imm_in(imm_in),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .alu_out(alu_out), .dmemload_out(dmemload_out), .next_pc_out(next_pc_out),
    .instruction_out(instruction_out), .imm_out(imm_out), .rd_out(rd_out),
    .rt_out(rt_out), .RegDest_out(RegDest_out), .memToReg_out(memToReg_out),
    .RegWrite_out(RegWrite_out), .jal_out(jal_out), .lui_out(lui_out),
    .halt_out(halt_out), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  assign obs = {alu_out, dmemload_out, next_pc_out, instruction_out, imm_out, rd_out,
                rt_out, RegDest_out, memToReg_out, RegWrite_out, jal_out, lui_out, halt_out};

  // Everything the MEM/WB latch should see, built from the instruction last accepted
  function automatic logic [160:0] model_out(input ex_t l, input logic [31:0] ld, input logic h);
    return {l.alu, ld, l.npc, l.instr, l.imm, l.rd, l.rt, l.rdst, l.m2r, l.rw, l.jal, l.lui, h};
  endfunction

  function automatic ex_t rand_ex();
    ex_t e;
    int  kind;
    e.alu = $urandom(); e.store = $urandom(); e.npc = $urandom(); e.instr = $urandom();
    kind  = $urandom_range(0, 2);
    e.mr  = (kind == 1);
    e.mw  = (kind == 2);
    e.m2r = 1'($urandom_range(0, 1)); e.rw = 1'($urandom_range(0, 1));
    e.jal = 1'($urandom_range(0, 1)); e.lui = 1'($urandom_range(0, 1));
    e.halt = 1'b0;
    e.rdst = 2'($urandom_range(0, 3));
    e.rd = 5'($urandom_range(0, 31)); e.rt = 5'($urandom_range(0, 31));
    e.imm = 16'($urandom_range(0, 65535));
    return e;
  endfunction

  task automatic drive_ex(input ex_t e);
    alu_in = e.alu; store_in = e.store; next_pc_in = e.npc; instruction_in = e.instr;
    memRead_in = e.mr; memWrite_in = e.mw; memToReg_in = e.m2r; RegWrite_in = e.rw;
    jal_in = e.jal; lui_in = e.lui; halt_in = e.halt; RegDest_in = e.rdst;
    rd_in = e.rd; rt_in = e.rt; imm_in = e.imm;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (obs !== '0) $display("[TB] FAIL reset_fields got %h exp 0", obs); else n_pass++;
    n_checks++; if ({dmemREN, dmemWEN, mem_busy, mem_err} !== 4'b0)
      $display("[TB] FAIL reset_ctrl got %b exp 0000", {dmemREN, dmemWEN, mem_busy, mem_err}); else n_pass++;
    n_checks++; if ({dmemaddr, dmemstore} !== 64'h0)
      $display("[TB] FAIL reset_bus got %h exp 0", {dmemaddr, dmemstore}); else n_pass++;
    #2 nRST = 1'b1;
    @(negedge CLK);
    n_checks++; if ({obs, mem_busy, dmemREN} !== '0)
      $display("[TB] FAIL reset_release got %h exp 0", {obs, mem_busy, dmemREN}); else n_pass++;
  endtask

  task automatic test_nonmem();
    ex_t e = '0;
    e.alu = 32'h1234; e.rw = 1'b1;
    @(negedge CLK); drive_ex(e); flush = 1'b0; ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    n_checks++; if (alu_out !== 32'h1234) $display("[TB] FAIL nonmem_alu got %h exp 00001234", alu_out); else n_pass++;
    n_checks++; if (RegWrite_out !== 1'b1) $display("[TB] FAIL nonmem_regwrite got %b exp 1", RegWrite_out); else n_pass++;
    n_checks++; if ({mem_busy, dmemREN} !== 2'b00)
      $display("[TB] FAIL nonmem_req got %b exp 00", {mem_busy, dmemREN}); else n_pass++;
  endtask

  task automatic test_load();
    ex_t e = '0;
    ex_t junk;
    e.alu = 32'h0000_0107; e.mr = 1'b1; e.rw = 1'b1; e.m2r = 1'b1;
    @(negedge CLK); drive_ex(e); ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (dmemaddr !== 32'h0000_0104) $display("[TB] FAIL load_addr c%0d got %h exp 00000104", c, dmemaddr); else n_pass++;
      n_checks++; if ({mem_busy, dmemREN, dmemWEN, mem_err} !== 4'b1100)
        $display("[TB] FAIL load_wait c%0d got %b exp 1100", c, {mem_busy, dmemREN, dmemWEN, mem_err}); else n_pass++;
      n_checks++; if (alu_out !== 32'h0000_0107) $display("[TB] FAIL load_hold c%0d got %h exp 00000107", c, alu_out); else n_pass++;
      junk = e; junk.alu = 32'hFFFF_FFF0 ^ 32'(c); junk.mr = 1'b0;
      drive_ex(junk); ihit = 1'b1;
      if (c == 2) begin dhit = 1'b1; dmemload = 32'hDEADBEEF; end
      @(negedge CLK);
    end
    dhit = 1'b0; ihit = 1'b0;
    n_checks++; if (dmemload_out !== 32'hDEADBEEF) $display("[TB] FAIL load_data got %h exp deadbeef", dmemload_out); else n_pass++;
    n_checks++; if ({mem_busy, dmemREN} !== 2'b00) $display("[TB] FAIL load_done got %b exp 00", {mem_busy, dmemREN}); else n_pass++;
    n_checks++; if (alu_out !== 32'h0000_0107) $display("[TB] FAIL load_ihit_ignored got %h exp 00000107", alu_out); else n_pass++;
  endtask

  task automatic test_store();
    ex_t e = '0;
    e.alu = 32'h0000_0200; e.store = 32'hCAFE0001; e.mw = 1'b1;
    @(negedge CLK); drive_ex(e); ihit = 1'b1; dhit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    n_checks++; if ({dmemWEN, dmemREN, mem_busy} !== 3'b101)
      $display("[TB] FAIL store_req got %b exp 101", {dmemWEN, dmemREN, mem_busy}); else n_pass++;
    n_checks++; if (dmemstore !== 32'hCAFE0001) $display("[TB] FAIL store_data got %h exp cafe0001", dmemstore); else n_pass++;
    @(negedge CLK); dhit = 1'b0;
    n_checks++; if ({dmemWEN, mem_busy} !== 2'b00) $display("[TB] FAIL store_one_cycle got %b exp 00", {dmemWEN, mem_busy}); else n_pass++;
    e = '0; e.alu = 32'h5555; e.rw = 1'b1;
    drive_ex(e); ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    n_checks++; if (alu_out !== 32'h5555) $display("[TB] FAIL store_next_adv got %h exp 00005555", alu_out); else n_pass++;
    n_checks++; if (dmemload_out !== 32'hDEADBEEF) $display("[TB] FAIL store_load_hold got %h exp deadbeef", dmemload_out); else n_pass++;
  endtask

  task automatic test_flush();
    ex_t e = '0;
    e.alu = 32'h77; e.mw = 1'b1; e.rw = 1'b1;
    @(negedge CLK); drive_ex(e); flush = 1'b1; ihit = 1'b1;
    @(negedge CLK); flush = 1'b0; ihit = 1'b0;
    n_checks++; if ({dmemWEN, mem_busy} !== 2'b00) $display("[TB] FAIL flush_req got %b exp 00", {dmemWEN, mem_busy}); else n_pass++;
    n_checks++; if ({RegWrite_out, alu_out} !== 33'h0) $display("[TB] FAIL flush_bubble got %h exp 0", {RegWrite_out, alu_out}); else n_pass++;
  endtask

  task automatic test_random(input int n);
    @(negedge CLK); nRST = 1'b0; #1 nRST = 1'b1;
    exp_lat = '0; exp_load = '0; exp_halt = 1'b0;
    for (int k = 0; k < n; k++) begin
      ex_t         e, junk;
      logic        fl, is_mem;
      int          w;
      logic [31:0] ld;
      e  = rand_ex();
      fl = ($urandom_range(0, 4) == 0);
      w  = $urandom_range(0, 2);
      ld = '0;
      @(negedge CLK); drive_ex(e); flush = fl; ihit = 1'b1; dhit = 1'($urandom_range(0, 1));
      @(negedge CLK); ihit = 1'b0; flush = 1'b0; dhit = 1'b0;
      is_mem   = ~fl & (e.mr | e.mw);
      exp_halt = exp_halt | (~fl & e.halt);
      exp_lat  = fl ? ex_t'('0) : e;
      n_checks++; if (obs !== model_out(exp_lat, exp_load, exp_halt))
        $display("[TB] FAIL rand_fields k%0d got %h exp %h", k, obs, model_out(exp_lat, exp_load, exp_halt)); else n_pass++;
      n_checks++; if ({mem_busy, dmemREN, dmemWEN} !== {is_mem, is_mem & e.mr, is_mem & e.mw})
        $display("[TB] FAIL rand_req k%0d got %b exp %b", k, {mem_busy, dmemREN, dmemWEN},
                 {is_mem, is_mem & e.mr, is_mem & e.mw}); else n_pass++;
      if (is_mem) begin
        n_checks++; if ({dmemaddr, dmemstore} !== {e.alu[31:2], 2'b00, e.store})
          $display("[TB] FAIL rand_bus k%0d got %h exp %h", k, {dmemaddr, dmemstore}, {e.alu[31:2], 2'b00, e.store}); else n_pass++;
        for (int c = 0; c <= w; c++) begin
          if (c > 0) begin
            n_checks++; if ({mem_busy, obs} !== {1'b1, model_out(exp_lat, exp_load, exp_halt)})
              $display("[TB] FAIL rand_hold k%0d c%0d got %b/%h", k, c, mem_busy, obs); else n_pass++;
          end
          junk = rand_ex(); drive_ex(junk); ihit = 1'($urandom_range(0, 1));
          if (c == w) begin dhit = 1'b1; ld = $urandom(); dmemload = ld; end
          @(negedge CLK);
        end
        dhit = 1'b0; ihit = 1'b0;
        if (e.mr) exp_load = ld;
        n_checks++; if ({mem_busy, dmemREN, dmemWEN, mem_err} !== 4'b0000)
          $display("[TB] FAIL rand_done k%0d got %b exp 0000", k, {mem_busy, dmemREN, dmemWEN, mem_err}); else n_pass++;
        n_checks++; if (obs !== model_out(exp_lat, exp_load, exp_halt))
          $display("[TB] FAIL rand_done_fields k%0d got %h exp %h", k, obs, model_out(exp_lat, exp_load, exp_halt)); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    ex_t prev, e;
    prev = rand_ex(); prev.mr = 1'b0; prev.mw = 1'b0;
    @(negedge CLK); drive_ex(prev); flush = 1'b0; ihit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      exp_lat = prev;
      n_checks++; if ({mem_busy, obs} !== {1'b0, model_out(exp_lat, exp_load, exp_halt)})
        $display("[TB] FAIL b2b k%0d got %b/%h exp 0/%h", k, mem_busy, obs, model_out(exp_lat, exp_load, exp_halt)); else n_pass++;
      e = rand_ex(); e.mr = 1'b0; e.mw = 1'b0;
      drive_ex(e); prev = e;
    end
    @(negedge CLK); ihit = 1'b0;
    exp_lat = prev;
    n_checks++; if (obs !== model_out(exp_lat, exp_load, exp_halt))
      $display("[TB] FAIL b2b_last got %h exp %h", obs, model_out(exp_lat, exp_load, exp_halt)); else n_pass++;
  endtask

  task automatic test_async_reset();
    ex_t e = '0;
    e.alu = 32'h40; e.mr = 1'b1;
    @(negedge CLK); drive_ex(e); ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    n_checks++; if (dmemREN !== 1'b1) $display("[TB] FAIL areset_pre got %b exp 1", dmemREN); else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_checks++; if ({dmemREN, mem_busy} !== 2'b00) $display("[TB] FAIL areset_req got %b exp 00", {dmemREN, mem_busy}); else n_pass++;
    n_checks++; if (obs !== '0) $display("[TB] FAIL areset_fields got %h exp 0", obs); else n_pass++;
    @(negedge CLK); #2 nRST = 1'b1;
    exp_lat = '0; exp_load = '0; exp_halt = 1'b0;
    @(negedge CLK);
    n_checks++; if ({dmemREN, mem_busy, obs} !== '0) $display("[TB] FAIL areset_release got nonzero %b", {dmemREN, mem_busy}); else n_pass++;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    ex_t e = '0;
    e.alu = 32'h80; e.mr = 1'b1;
    @(negedge CLK); drive_ex(e); ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (mem_err !== 1'b0) $display("[TB] FAIL timeout_early got %b exp 0", mem_err); else n_pass++;
    @(negedge CLK);
    n_checks++; if ({mem_err, mem_busy} !== 2'b11) $display("[TB] FAIL timeout_set got %b exp 11", {mem_err, mem_busy}); else n_pass++;
    dhit = 1'b1; dmemload = 32'h1357_9BDF;
    @(negedge CLK); dhit = 1'b0;
    n_checks++; if ({mem_err, mem_busy} !== 2'b10) $display("[TB] FAIL timeout_sticky got %b exp 10", {mem_err, mem_busy}); else n_pass++;
    n_checks++; if (dmemload_out !== 32'h1357_9BDF) $display("[TB] FAIL timeout_data got %h exp 13579bdf", dmemload_out); else n_pass++;
    nRST = 1'b0; #1;
    n_checks++; if (mem_err !== 1'b0) $display("[TB] FAIL timeout_reset got %b exp 0", mem_err); else n_pass++;
    #1 nRST = 1'b1;
  endtask
`endif

  task automatic test_halt();
    ex_t e = '0;
    e.halt = 1'b1; e.mr = 1'b1; e.rw = 1'b1;
    @(negedge CLK); drive_ex(e); ihit = 1'b1;
    @(negedge CLK); ihit = 1'b0;
    n_checks++; if (halt_out !== 1'b1) $display("[TB] FAIL halt_out got %b exp 1", halt_out); else n_pass++;
    n_checks++; if ({dmemREN, mem_busy} !== 2'b00) $display("[TB] FAIL halt_noreq got %b exp 00", {dmemREN, mem_busy}); else n_pass++;
    e = '0; e.rw = 1'b1;
    drive_ex(e); flush = 1'b1; ihit = 1'b1;
    @(negedge CLK); flush = 1'b0; ihit = 1'b0;
    n_checks++; if ({halt_out, RegWrite_out} !== 2'b10) $display("[TB] FAIL halt_sticky got %b exp 10", {halt_out, RegWrite_out}); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_flush();
    test_random(40);
    test_back_to_back();
    test_async_reset();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
